// File: rtl/phase_scheduler.sv
// Traffic-light phase scheduler: Moore FSM stepping MG/MY/AR1/WALK/SG/SY/AR2 on Tick pulses.
// Define SIDE_EXTEND_EN to let a present side vehicle stretch side green up to T_SG_MAX.
module phase_scheduler #(
  parameter int T_MG     = 8,
  parameter int T_Y      = 2,
  parameter int T_AR     = 1,
  parameter int T_SG     = 4,
  parameter int T_WALK   = 4,
  parameter int T_SG_MAX = 8
) (
  input  logic       Clk,
  input  logic       ResetN,
  input  logic       Tick,
  input  logic       Sensor,
  input  logic       WalkButton,
  output logic       MainGreen,
  output logic       MainYellow,
  output logic       MainRed,
  output logic       SideGreen,
  output logic       SideYellow,
  output logic       SideRed,
  output logic       WalkLight,
  output logic [2:0] Phase
);

  localparam int CW = 8;

  // Last counter value of each phase: the phase ends on the Tick seen at this count.
  localparam logic [CW-1:0] MG_LAST   = CW'(T_MG - 1);
  localparam logic [CW-1:0] Y_LAST    = CW'(T_Y - 1);
  localparam logic [CW-1:0] AR_LAST   = CW'(T_AR - 1);
  localparam logic [CW-1:0] SG_LAST   = CW'(T_SG - 1);
  localparam logic [CW-1:0] WALK_LAST = CW'(T_WALK - 1);

  typedef enum logic [2:0] {
    S_MG   = 3'd0,
    S_MY   = 3'd1,
    S_AR1  = 3'd2,
    S_WALK = 3'd3,
    S_SG   = 3'd4,
    S_SY   = 3'd5,
    S_AR2  = 3'd6
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          walk_req_q, walk_req_d;
  logic [CW-1:0] last;
  logic          expire;

`ifdef SIDE_EXTEND_EN
  localparam logic [CW-1:0] SG_MAX_LAST = CW'(T_SG_MAX - 1);

  logic [CW-1:0] sg_last_q, sg_last_d;
  logic [CW-1:0] sg_last_ext;

  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      sg_last_q <= SG_LAST;
    end else begin
      sg_last_q <= sg_last_d;
    end
  end

  // Each extension adds two Ticks but never pushes side green past the ceiling.
  always_comb begin
    sg_last_ext = sg_last_q + CW'(2);
    if (sg_last_ext > SG_MAX_LAST) begin
      sg_last_ext = SG_MAX_LAST;
    end
  end
`endif

  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      state_q    <= S_MG;
      cnt_q      <= '0;
      walk_req_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      walk_req_q <= walk_req_d;
    end
  end

  always_comb begin
    last = MG_LAST;
    case (state_q)
      S_MG:          last = MG_LAST;
      S_MY, S_SY:    last = Y_LAST;
      S_AR1, S_AR2:  last = AR_LAST;
      S_WALK:        last = WALK_LAST;
`ifdef SIDE_EXTEND_EN
      S_SG:          last = sg_last_q;
`else
      S_SG:          last = SG_LAST;
`endif
      default:       last = MG_LAST;
    endcase
  end

  assign expire = Tick && (cnt_q >= last);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
`ifdef SIDE_EXTEND_EN
    sg_last_d = sg_last_q;
`endif
    if (Tick) begin
      cnt_d = cnt_q + 1'b1;
    end

    case (state_q)
      S_MG: begin
        if (expire) begin
          if (Sensor || walk_req_q) begin
            state_d = S_MY;
          end else begin
            // Minimum time served with nobody waiting: park at the last count.
            cnt_d = MG_LAST;
          end
        end
      end
      S_MY: begin
        if (expire) state_d = S_AR1;
      end
      S_AR1: begin
        if (expire) state_d = walk_req_q ? S_WALK : S_SG;
      end
      S_WALK: begin
        if (expire) state_d = S_MG;
      end
      S_SG: begin
        if (expire) begin
`ifdef SIDE_EXTEND_EN
          if (Sensor && (sg_last_q < SG_MAX_LAST)) begin
            sg_last_d = sg_last_ext;
          end else begin
            state_d = S_SY;
          end
`else
          state_d = S_SY;
`endif
        end
      end
      S_SY: begin
        if (expire) state_d = S_AR2;
      end
      S_AR2: begin
        if (expire) state_d = S_MG;
      end
      default: begin
        state_d = S_MG;
      end
    endcase

    if (state_d != state_q) begin
      cnt_d = '0;
    end
`ifdef SIDE_EXTEND_EN
    if (state_q != S_SG) begin
      sg_last_d = SG_LAST;
    end
`endif
  end

  // Clearing on WALK entry takes priority over a press on that same edge.
  always_comb begin
    walk_req_d = walk_req_q | (WalkButton && (state_q != S_WALK));
    if ((state_d == S_WALK) && (state_q != S_WALK)) begin
      walk_req_d = 1'b0;
    end
  end

  always_comb begin
    MainGreen  = 1'b0;
    MainYellow = 1'b0;
    MainRed    = 1'b1;
    SideGreen  = 1'b0;
    SideYellow = 1'b0;
    SideRed    = 1'b1;
    WalkLight  = 1'b0;
    case (state_q)
      S_MG: begin
        MainGreen = 1'b1;
        MainRed   = 1'b0;
      end
      S_MY: begin
        MainYellow = 1'b1;
        MainRed    = 1'b0;
      end
      S_WALK: WalkLight = 1'b1;
      S_SG: begin
        SideGreen = 1'b1;
        SideRed   = 1'b0;
      end
      S_SY: begin
        SideYellow = 1'b1;
        SideRed    = 1'b0;
      end
      default: ;
    endcase
  end

  assign Phase = state_q;

endmodule

// File: tb/tb_phase_scheduler.sv
// Directed bench for phase_scheduler: walks each phase sequence Tick by Tick against hand-built expectations.
module tb_phase_scheduler;

  logic       Clk = 1'b0;
  logic       ResetN = 1'b0;
  logic       Tick = 1'b0;
  logic       Sensor = 1'b0;
  logic       WalkButton = 1'b0;
  logic       MainGreen, MainYellow, MainRed;
  logic       SideGreen, SideYellow, SideRed;
  logic       WalkLight;
  logic [2:0] Phase;

  int total = 0;
  int bad   = 0;

  // Lamp vector order: {MainG, MainY, MainR, SideG, SideY, SideR, Walk}
  localparam logic [6:0] L_MG   = 7'b100_001_0;
  localparam logic [6:0] L_MY   = 7'b010_001_0;
  localparam logic [6:0] L_AR   = 7'b001_001_0;
  localparam logic [6:0] L_WALK = 7'b001_001_1;
  localparam logic [6:0] L_SG   = 7'b001_100_0;
  localparam logic [6:0] L_SY   = 7'b001_010_0;

  phase_scheduler dut (
    .Clk        (Clk),
    .ResetN     (ResetN),
    .Tick       (Tick),
    .Sensor     (Sensor),
    .WalkButton (WalkButton),
    .MainGreen  (MainGreen),
    .MainYellow (MainYellow),
    .MainRed    (MainRed),
    .SideGreen  (SideGreen),
    .SideYellow (SideYellow),
    .SideRed    (SideRed),
    .WalkLight  (WalkLight),
    .Phase      (Phase)
  );

  always #5 Clk = ~Clk;

  function automatic logic [6:0] lamps();
    return {MainGreen, MainYellow, MainRed, SideGreen, SideYellow, SideRed, WalkLight};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end else begin
      $display("ok   %s: %0h", tag, obs);
    end
  endtask

  // One Tick cycle followed by one idle cycle; outputs are sampled on the falling edge.
  task automatic do_tick(input logic btn);
    @(negedge Clk);
    Tick = 1'b1;
    WalkButton = btn;
    @(negedge Clk);
    Tick = 1'b0;
    WalkButton = 1'b0;
    @(negedge Clk);
  endtask

  // Expect the given phase and lamps to hold for n Ticks.
  task automatic run(input string tag, input logic [2:0] ph, input logic [6:0] lp, input int n);
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s phase t%0d", tag, i), 32'(Phase), 32'(ph));
      check($sformatf("%s lamps t%0d", tag, i), 32'(lamps()), 32'(lp));
      do_tick(1'b0);
    end
  endtask

  task automatic do_reset();
    @(negedge Clk);
    ResetN = 1'b0;
    Tick = 1'b0;
    WalkButton = 1'b0;
    repeat (2) @(negedge Clk);
    ResetN = 1'b1;
    @(negedge Clk);
  endtask

  initial begin
    // Reset values while ResetN is held low
    #12;
    check("reset phase", 32'(Phase), 32'd0);
    check("reset lamps", 32'(lamps()), 32'(L_MG));
    @(negedge Clk);
    ResetN = 1'b1;
    @(negedge Clk);

    // Idle road: MG forever
    Sensor = 1'b0;
    run("idle MG", 3'd0, L_MG, 20);
    check("idle after 20", 32'(Phase), 32'd0);

    // Side vehicle cycle, with idle clocks inside MY
    do_reset();
    Sensor = 1'b1;
    run("side MG", 3'd0, L_MG, 8);
    run("side MY", 3'd1, L_MY, 1);
    repeat (10) @(negedge Clk);
    run("side MY hold", 3'd1, L_MY, 1);
    run("side AR1", 3'd2, L_AR, 1);
`ifdef SIDE_EXTEND_EN
    run("side SG", 3'd4, L_SG, 8);
`else
    run("side SG", 3'd4, L_SG, 4);
`endif
    run("side SY", 3'd5, L_SY, 2);
    run("side AR2", 3'd6, L_AR, 1);
    check("side back MG", 32'(Phase), 32'd0);
    Sensor = 1'b0;

    // Walk request: pulse at Tick 3, press on WALK entry and during WALK are dropped
    do_reset();
    run("walk MG a", 3'd0, L_MG, 3);
    @(negedge Clk);
    WalkButton = 1'b1;
    @(negedge Clk);
    WalkButton = 1'b0;
    run("walk MG b", 3'd0, L_MG, 5);
    run("walk MY", 3'd1, L_MY, 2);
    check("walk AR1 phase", 32'(Phase), 32'd2);
    do_tick(1'b1);
    check("walk WALK phase", 32'(Phase), 32'd3);
    check("walk WALK lamps", 32'(lamps()), 32'(L_WALK));
    do_tick(1'b1);
    run("walk WALK", 3'd3, L_WALK, 3);
    run("walk MG after", 3'd0, L_MG, 12);
    check("walk req cleared", 32'(Phase), 32'd0);

    // Walk and side together: walk first, side after the next MG minimum
    do_reset();
    run("both MG a", 3'd0, L_MG, 1);
    Sensor = 1'b1;
    do_tick(1'b1);
    run("both MG b", 3'd0, L_MG, 6);
    run("both MY", 3'd1, L_MY, 2);
    run("both AR1", 3'd2, L_AR, 1);
    run("both WALK", 3'd3, L_WALK, 4);
    run("both MG2", 3'd0, L_MG, 8);
    run("both MY2", 3'd1, L_MY, 2);
    run("both AR1b", 3'd2, L_AR, 1);
    check("both SG phase", 32'(Phase), 32'd4);
    check("both SG lamps", 32'(lamps()), 32'(L_SG));

    // Asynchronous reset during SG, then full MG minimum
    do_reset();
    Sensor = 1'b1;
    run("rst MG", 3'd0, L_MG, 8);
    run("rst MY", 3'd1, L_MY, 2);
    run("rst AR1", 3'd2, L_AR, 1);
    run("rst SG", 3'd4, L_SG, 2);
    #2;
    ResetN = 1'b0;
    #1;
    check("async rst phase", 32'(Phase), 32'd0);
    check("async rst lamps", 32'(lamps()), 32'(L_MG));
    @(negedge Clk);
    ResetN = 1'b1;
    @(negedge Clk);
    run("rst MG full", 3'd0, L_MG, 8);
    check("rst then MY", 32'(Phase), 32'd1);
    Sensor = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/phase_scheduler.md
PHASE_SCHEDULER -- requirements
Module: phase_scheduler

Interface
REQ-001 Parameter T_MG, default 8, minimum main-green duration in Tick pulses.
REQ-002 Parameter T_Y, default 2, yellow duration in Tick pulses (main and side).
REQ-003 Parameter T_AR, default 1, all-red clearance duration in Tick pulses.
REQ-004 Parameter T_SG, default 4, base side-green duration in Tick pulses.
REQ-005 Parameter T_WALK, default 4, walk interval in Tick pulses.
REQ-006 Parameter T_SG_MAX, default 8, side-green ceiling in Tick pulses; only used with SIDE_EXTEND_EN.
REQ-007 Clk  input  1  system clock, rising edge.
REQ-008 ResetN  input  1  asynchronous, active-low reset.
REQ-009 Tick  input  1  one-Clk-wide timebase pulse; the only input that advances timers.
REQ-010 Sensor  input  1  side-road vehicle present, level.
REQ-011 WalkButton  input  1  pedestrian request, level.
REQ-012 MainGreen, MainYellow, MainRed  output  1 each  main-road lamps.
REQ-013 SideGreen, SideYellow, SideRed  output  1 each  side-road lamps.
REQ-014 WalkLight  output  1  pedestrian walk lamp.
REQ-015 Phase  output  3  current state code: MG=0, MY=1, AR1=2, WALK=3, SG=4, SY=5, AR2=6.

Function
REQ-016 The block SHALL be a Moore FSM; all outputs SHALL be decoded from registered state only, with no combinational input-to-output path.
REQ-017 Lamps per state: MG main G/side R; MY main Y/side R; AR1, AR2, WALK both R; SG main R/side G; SY main R/side Y; WalkLight=1 only in WALK.
REQ-018 Exactly one lamp per road SHALL be lit in every state.
REQ-019 A tick counter SHALL clear on state entry and increment on each Tick; a state of duration T SHALL exit on the Clk edge where Tick=1 and counter=T-1, so it lasts exactly T Tick pulses.
REQ-020 Clk cycles without Tick SHALL NOT change counter or state.
REQ-021 MG: when min-time expiry occurs and (Sensor=1 or WalkReq=1), go to MY; otherwise remain in MG and hold counter at T_MG-1 until a request arrives, then exit on the next Tick.
REQ-022 MY -> AR1 after T_Y; AR1 -> WALK if WalkReq=1, else SG, after T_AR.
REQ-023 WALK -> MG after T_WALK; SG -> SY after side-green time; SY -> AR2 after T_Y; AR2 -> MG after T_AR.
REQ-024 WalkReq SHALL set on any Clk edge with WalkButton=1 outside WALK; it SHALL clear on WALK entry; presses during WALK SHALL be ignored.
REQ-025 If WalkButton=1 on the edge entering WALK, clear SHALL win.
REQ-026 When WalkReq and Sensor are both pending at AR1, WALK SHALL be served first; side traffic is served after the next MG minimum.
REQ-027 Sensor SHALL be sampled only at MG and SG decision edges; it is not latched.
REQ-028 Invalid Phase encodings SHALL recover to MG on the next Clk edge.

Reset
REQ-029 ResetN=0 SHALL immediately force state MG, counter 0, WalkReq 0, independent of Clk.
REQ-030 Outputs in reset: MainGreen=1, SideRed=1, Phase=0, all others 0.
REQ-031 Reset asserted mid-phase SHALL abandon the phase; after release, MG runs a full T_MG.

Configuration
REQ-032 Macro SIDE_EXTEND_EN: when defined, at SG base expiry with Sensor=1 the counter SHALL extend by 2 Ticks per decision, repeatedly, until Sensor=0 or total side green reaches T_SG_MAX, then go to SY.
REQ-033 Without SIDE_EXTEND_EN, side green SHALL be exactly T_SG and T_SG_MAX SHALL be unused.

Verification
REQ-034 Reset; Sensor=0, WalkButton=0, 20 Ticks -> Phase stays 0, MainGreen=1 throughout.
REQ-035 Sensor=1 from reset -> MG 8 Ticks, MY 2, AR1 1, SG 4, SY 2, AR2 1, then Phase=0; without the macro, SideGreen is high for exactly 4 Ticks.
REQ-036 One-cycle WalkButton pulse at Tick 3 -> MY at Tick 8, AR1, WALK with WalkLight=1 for 4 Ticks, then MG; SideGreen never asserts.
REQ-037 WalkButton and Sensor both high at Tick 2 -> sequence MG, MY, AR1, WALK, MG (8 Ticks), MY, AR1, SG.
REQ-038 ResetN pulsed low during SG -> outputs return to reset values asynchronously; MG then lasts a full 8 Ticks.
REQ-039 With SIDE_EXTEND_EN and Sensor held at 1 -> SideGreen lasts exactly 8 Ticks, then SY.
